// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: mode/opcode/EX command codes, sequencer state type and arithmetic decode helper
package pipelined_control_unit_pkg;
  localparam logic [1:0] MODE_ARITHMETIC = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;
  localparam logic [3:0] EX_CMP = 4'b0100;
  localparam logic [3:0] EX_TST = 4'b0110;
  localparam logic [3:0] EX_LDR = 4'b0010;
  localparam logic [3:0] EX_STR = 4'b0010;
  localparam logic [3:0] EX_MUL = 4'b1010;
  typedef enum logic {RUN, MUL_WAIT} mul_state_t;
  function automatic logic [4:0] arith_decode(input logic [3:0] op);
    case (op)
      OP_MOV: return {1'b1, EX_MOV};
      OP_MVN: return {1'b1, EX_MVN};
      OP_ADD: return {1'b1, EX_ADD};
      OP_ADC: return {1'b1, EX_ADC};
      OP_SUB: return {1'b1, EX_SUB};
      OP_SBC: return {1'b1, EX_SBC};
      OP_AND: return {1'b1, EX_AND};
      OP_ORR: return {1'b1, EX_ORR};
      OP_EOR: return {1'b1, EX_EOR};
      OP_CMP: return {1'b1, EX_CMP};
      OP_TST: return {1'b1, EX_TST};
      default: return 5'b0;
    endcase
  endfunction
endpackage

// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID-stage inputs (valid/S/mode/op_code/is_mul/freeze/flush) and registered ID/EX controls; master drives ID, slave is the control unit
interface pipelined_control_unit_if #(parameter int EX_CMD_W = 4);
  logic instr_valid, S, is_mul, freeze, flush;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic out_valid, mem_read, mem_write, WB_en, B, SR_update, has_src1, stall_req, illegal_instr;
  logic [EX_CMD_W-1:0] EX_command;
  modport master(output instr_valid, S, mode, op_code, is_mul, freeze, flush,
                 input out_valid, EX_command, mem_read, mem_write, WB_en, B, SR_update, has_src1, stall_req, illegal_instr);
  modport slave(input instr_valid, S, mode, op_code, is_mul, freeze, flush,
                output out_valid, EX_command, mem_read, mem_write, WB_en, B, SR_update, has_src1, stall_req, illegal_instr);
endinterface

// File: rtl/pipelined_control_unit_mul_sequencer.sv
// mul_sequencer: RUN/MUL_WAIT state and wait counter; busy (= stall_req) stays high MUL_CYCLES-1 cycles after start, cleared by flush or rst
module mul_sequencer
  import pipelined_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  output logic busy
);
  mul_state_t state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      busy <= 1'b0;
    end else if (state == MUL_WAIT) begin
      if (flush || cnt == CNT_W'(1)) begin
        state <= RUN;
        cnt <= '0;
        busy <= 1'b0;
      end else cnt <= cnt - 1'b1;
    end else if (start && MUL_CYCLES > 1) begin
      state <= MUL_WAIT;
      cnt <= CNT_W'(MUL_CYCLES - 1);
      busy <= 1'b1;
    end
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered ID/EX control decode with bubbles on flush/freeze/invalid, illegal-opcode pulse and MUL stall via bus (slave), clk, rst
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int EX_CMD_W = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  pipelined_control_unit_if.slave bus
);
  logic [3:0] d_cmd;
  logic [4:0] ar;
  logic d_rd, d_wr, d_wb, d_b, d_legal, busy, normal, issue, start;
  always_comb begin
    ar = arith_decode(bus.op_code);
    d_cmd = '0;
    d_rd = 1'b0;
    d_wr = 1'b0;
    d_wb = 1'b0;
    d_b = 1'b0;
    d_legal = 1'b1;
    case (bus.mode)
      MODE_MEM: begin
        d_cmd = bus.S ? EX_LDR : EX_STR;
        d_rd = bus.S;
        d_wr = !bus.S;
        d_wb = bus.S;
      end
      MODE_ARITHMETIC: begin
        d_cmd = bus.is_mul ? EX_MUL : ar[3:0];
        d_legal = bus.is_mul || ar[4];
        d_wb = bus.is_mul || (ar[4] && bus.op_code != OP_CMP && bus.op_code != OP_TST);
      end
      MODE_BRANCH: d_b = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end
  assign normal = bus.instr_valid && !bus.flush && !busy && !bus.freeze;
  assign issue = normal && d_legal;
  assign start = issue && bus.mode == MODE_ARITHMETIC && bus.is_mul;
  assign bus.stall_req = busy;
  assign bus.has_src1 = !(bus.mode == MODE_BRANCH ||
                          (bus.mode == MODE_ARITHMETIC && (bus.op_code == OP_MOV || bus.op_code == OP_MVN)));
  mul_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) u_seq (
    .clk(clk), .rst(rst), .start(start), .flush(bus.flush), .busy(busy)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.EX_command <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.WB_en <= 1'b0;
      bus.B <= 1'b0;
      bus.SR_update <= 1'b0;
      bus.illegal_instr <= 1'b0;
    end else begin
      bus.out_valid <= issue;
      bus.EX_command <= issue ? EX_CMD_W'(d_cmd) : '0;
      bus.mem_read <= issue && d_rd;
      bus.mem_write <= issue && d_wr;
      bus.WB_en <= issue && d_wb;
      bus.B <= issue && d_b;
      bus.SR_update <= issue && bus.S && bus.mode == MODE_ARITHMETIC;
      bus.illegal_instr <= normal && !d_legal;
    end
  end
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed checks of decode, bubbles, illegal pulse, MUL stall (MUL_CYCLES 3 and 1), flush and async reset
module tb_pipelined_control_unit;
  localparam logic [1:0] M_AR = 2'b00, M_MEM = 2'b01, M_BR = 2'b10, M_BAD = 2'b11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  pipelined_control_unit_if i3();
  pipelined_control_unit_if i1();
  pipelined_control_unit #(.MUL_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
  pipelined_control_unit #(.MUL_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  function automatic logic [11:0] o3();
    return {i3.out_valid, i3.EX_command, i3.mem_read, i3.mem_write, i3.WB_en, i3.B, i3.SR_update, i3.illegal_instr, i3.stall_req};
  endfunction
  function automatic logic [11:0] o1();
    return {i1.out_valid, i1.EX_command, i1.mem_read, i1.mem_write, i1.WB_en, i1.B, i1.SR_update, i1.illegal_instr, i1.stall_req};
  endfunction
  task automatic drive(input logic v, input logic s, input logic [1:0] m, input logic [3:0] op,
                       input logic mul, input logic frz, input logic fl);
    {i3.instr_valid, i3.S, i3.mode, i3.op_code, i3.is_mul, i3.freeze, i3.flush} = {v, s, m, op, mul, frz, fl};
    {i1.instr_valid, i1.S, i1.mode, i1.op_code, i1.is_mul, i1.freeze, i1.flush} = {v, s, m, op, mul, frz, fl};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    drive(0, 0, M_AR, 4'h0, 0, 0, 0);
    #3;
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL reset_u3: got %h want %h", o3(), 12'h0); end
    n_checks++; if (o1() !== 12'h0) begin n_fail++; $display("FAIL reset_u1: got %h want %h", o1(), 12'h0); end
    step();
    rst = 1'b0;
  endtask
  task automatic test_add();
    drive(1, 1, M_AR, 4'b0100, 0, 0, 0);
    #1;
    n_checks++; if (i3.has_src1 !== 1'b1) begin n_fail++; $display("FAIL add_src1: got %b want 1", i3.has_src1); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0010100}) begin n_fail++; $display("FAIL add: got %h want %h", o3(), {1'b1, 4'h2, 7'b0010100}); end
  endtask
  task automatic test_ldr_freeze();
    drive(1, 1, M_MEM, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b1010000}) begin n_fail++; $display("FAIL ldr: got %h want %h", o3(), {1'b1, 4'h2, 7'b1010000}); end
    drive(1, 1, M_MEM, 4'b0100, 0, 1, 0);
    step();
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL freeze_bubble: got %h want %h", o3(), 12'h0); end
    drive(1, 0, M_BAD, 4'h0, 0, 1, 0);
    step();
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL freeze_illegal: got %h want %h", o3(), 12'h0); end
  endtask
  task automatic test_decode();
    drive(1, 0, M_MEM, 4'b0100, 0, 0, 0);
    #1;
    n_checks++; if (i3.has_src1 !== 1'b1) begin n_fail++; $display("FAIL str_src1: got %b want 1", i3.has_src1); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0100000}) begin n_fail++; $display("FAIL str: got %h want %h", o3(), {1'b1, 4'h2, 7'b0100000}); end
    drive(1, 1, M_AR, 4'b1010, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h4, 7'b0000100}) begin n_fail++; $display("FAIL cmp: got %h want %h", o3(), {1'b1, 4'h4, 7'b0000100}); end
    drive(1, 0, M_AR, 4'b1000, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h6, 7'b0000000}) begin n_fail++; $display("FAIL tst: got %h want %h", o3(), {1'b1, 4'h6, 7'b0000000}); end
    drive(1, 0, M_AR, 4'b0001, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h8, 7'b0010000}) begin n_fail++; $display("FAIL eor: got %h want %h", o3(), {1'b1, 4'h8, 7'b0010000}); end
    drive(1, 0, M_BR, 4'b0000, 0, 0, 0);
    #1;
    n_checks++; if (i3.has_src1 !== 1'b0) begin n_fail++; $display("FAIL br_src1: got %b want 0", i3.has_src1); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h0, 7'b0001000}) begin n_fail++; $display("FAIL branch: got %h want %h", o3(), {1'b1, 4'h0, 7'b0001000}); end
    drive(1, 0, M_AR, 4'b1101, 0, 0, 0);
    #1;
    n_checks++; if (i3.has_src1 !== 1'b0) begin n_fail++; $display("FAIL mov_src1: got %b want 0", i3.has_src1); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h1, 7'b0010000}) begin n_fail++; $display("FAIL mov: got %h want %h", o3(), {1'b1, 4'h1, 7'b0010000}); end
    drive(1, 0, M_AR, 4'b1111, 0, 0, 0);
    #1;
    n_checks++; if (i3.has_src1 !== 1'b0) begin n_fail++; $display("FAIL mvn_src1: got %b want 0", i3.has_src1); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h9, 7'b0010000}) begin n_fail++; $display("FAIL mvn: got %h want %h", o3(), {1'b1, 4'h9, 7'b0010000}); end
  endtask
  task automatic test_invalid_illegal();
    drive(0, 1, M_AR, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL invalid_bubble: got %h want %h", o3(), 12'h0); end
    drive(1, 0, M_BAD, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== 12'b000000000010) begin n_fail++; $display("FAIL illegal_mode: got %h want %h", o3(), 12'b000000000010); end
    drive(1, 1, M_AR, 4'b0111, 0, 0, 0);
    step();
    n_checks++; if (o3() !== 12'b000000000010) begin n_fail++; $display("FAIL illegal_op: got %h want %h", o3(), 12'b000000000010); end
    drive(1, 0, M_AR, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0010000}) begin n_fail++; $display("FAIL illegal_pulse_end: got %h want %h", o3(), {1'b1, 4'h2, 7'b0010000}); end
  endtask
  task automatic test_back_to_back_mul();
    drive(1, 0, M_AR, 4'b0000, 1, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'hA, 7'b0010001}) begin n_fail++; $display("FAIL mul3_issue: got %h want %h", o3(), {1'b1, 4'hA, 7'b0010001}); end
    n_checks++; if (o1() !== {1'b1, 4'hA, 7'b0010000}) begin n_fail++; $display("FAIL mul1_issue: got %h want %h", o1(), {1'b1, 4'hA, 7'b0010000}); end
    drive(1, 0, M_AR, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== 12'b000000000001) begin n_fail++; $display("FAIL mul3_wait1: got %h want %h", o3(), 12'b000000000001); end
    n_checks++; if (o1() !== {1'b1, 4'h2, 7'b0010000}) begin n_fail++; $display("FAIL mul1_next: got %h want %h", o1(), {1'b1, 4'h2, 7'b0010000}); end
    step();
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL mul3_wait2: got %h want %h", o3(), 12'h0); end
    n_checks++; if (i1.stall_req !== 1'b0) begin n_fail++; $display("FAIL mul1_stall: got %b want 0", i1.stall_req); end
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0010000}) begin n_fail++; $display("FAIL mul3_next: got %h want %h", o3(), {1'b1, 4'h2, 7'b0010000}); end
  endtask
  task automatic test_mul_flush();
    drive(1, 1, M_AR, 4'b0000, 1, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'hA, 7'b0010101}) begin n_fail++; $display("FAIL mulf_issue: got %h want %h", o3(), {1'b1, 4'hA, 7'b0010101}); end
    drive(1, 0, M_AR, 4'b0100, 0, 0, 1);
    step();
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL mulf_flush: got %h want %h", o3(), 12'h0); end
    drive(1, 0, M_AR, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0010000}) begin n_fail++; $display("FAIL mulf_run: got %h want %h", o3(), {1'b1, 4'h2, 7'b0010000}); end
  endtask
  task automatic test_async_reset();
    drive(1, 1, M_AR, 4'b0100, 0, 0, 0);
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL areset_live: got %h want %h", o3(), 12'h0); end
    step();
    rst = 1'b0;
    drive(1, 0, M_AR, 4'b0000, 1, 0, 0);
    step();
    n_checks++; if (i3.stall_req !== 1'b1) begin n_fail++; $display("FAIL areset_mul_stall: got %b want 1", i3.stall_req); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o3() !== 12'h0) begin n_fail++; $display("FAIL areset_mul: got %h want %h", o3(), 12'h0); end
    step();
    rst = 1'b0;
    drive(1, 0, M_AR, 4'b0100, 0, 0, 0);
    step();
    n_checks++; if (o3() !== {1'b1, 4'h2, 7'b0010000}) begin n_fail++; $display("FAIL areset_resume: got %h want %h", o3(), {1'b1, 4'h2, 7'b0010000}); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_ldr_freeze();
    test_decode();
    test_invalid_illegal();
    test_back_to_back_mul();
    test_mul_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered ID-stage control unit for the 32-bit ARM pipeline. Decodes S/mode/op_code into execute/memory/writeback controls and drives them straight into the ID/EX boundary, so this block owns the control half of the ID/EX register.
- Adds behaviour the combinational unit lacks:
  - bubble insertion on freeze (hazard) and flush (taken branch);
  - illegal-opcode detection;
  - a multi-cycle MUL sequencer that stalls fetch/decode for a parametrised latency.

Parameters:
- EX_CMD_W, 4, width of EX_command.
- MUL_CYCLES, 3, execute-stage cycles a MUL occupies (legal range 1..15).
- CNT_W, 4, width of the MUL wait counter. Must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  ID holds a real instruction.
- S  in  1  instruction S bit (L bit for memory mode).
- mode  in  2  instruction mode field (MODE_MEM / MODE_ARITHMETIC / MODE_BRANCH).
- op_code  in  4  instruction opcode field.
- is_mul  in  1  MUL encoding detected by the ID decoder; valid only with MODE_ARITHMETIC.
- freeze  in  1  hazard unit requests a bubble.
- flush  in  1  branch taken in EX; kill the ID instruction.
- out_valid  out  1  registered: EX control bundle is live.
- EX_command  out  EX_CMD_W  registered ALU command.
- mem_read  out  1  registered.
- mem_write  out  1  registered.
- WB_en  out  1  registered.
- B  out  1  registered branch flag.
- SR_update  out  1  registered status-register update enable.
- has_src1  out  1  combinational, from the current ID inputs; feeds the hazard unit.
- stall_req  out  1  registered: hold PC and IF/ID; high while a MUL is in progress.
- illegal_instr  out  1  registered one-cycle pulse: undefined opcode decoded.

Behaviour:
- Reset (asynchronous): all registered outputs 0, FSM = RUN, counter = 0.
- Latency: decode results appear on the registered outputs one clk after the ID inputs are sampled.
- Bubble: out_valid=0, EX_command=0, mem_read=mem_write=WB_en=B=SR_update=0.
- Priority each cycle: rst > flush > MUL-wait > freeze > !instr_valid > normal decode.
  - flush, freeze or !instr_valid loads a bubble.
  - freeze never sets illegal_instr.
- Decode table (normal path):
  - MODE_MEM, S=0: EX_STR, mem_write=1.
  - MODE_MEM, S=1: EX_LDR, mem_read=1, WB_en=1.
  - MODE_ARITHMETIC, is_mul=1: EX_MUL, WB_en=1 (see sequencer below).
  - MODE_ARITHMETIC, MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR: matching EX_ code, WB_en=1.
  - MODE_ARITHMETIC, CMP/TST: EX_CMP/EX_TST, WB_en=0.
  - MODE_BRANCH: B=1, EX_command=0.
  - Any other mode/op_code combination: bubble, plus illegal_instr=1 for that cycle.
- SR_update = S && mode==MODE_ARITHMETIC && the instruction is legal. The S bit in memory mode never updates SR.
- has_src1 = 0 for MOV, MVN or branch; 1 otherwise. Evaluated from the ID inputs, not the registered outputs.
- FSM states: RUN and MUL_WAIT.
  - RUN: a legal MUL with no flush/freeze issues EX_MUL for one cycle.
    - If MUL_CYCLES>1: counter <= MUL_CYCLES-1, stall_req<=1, go to MUL_WAIT.
    - If MUL_CYCLES==1: stay in RUN; stall_req is never asserted.
  - MUL_WAIT: load a bubble every cycle and decrement the counter.
    - When the counter reaches 1: stall_req<=0, next state RUN.
    - Total stall_req high time is exactly MUL_CYCLES-1 cycles.
  - Flush in MUL_WAIT: counter<=0, stall_req<=0, go to RUN, load a bubble.
  - Freeze in MUL_WAIT: ignored, because the stall already holds the upstream stages.
- Reset mid-MUL: immediate return to RUN; all outputs 0.
- Back-to-back MULs: the second MUL is held in IF/ID by stall_req and is re-decoded in the first RUN cycle.

Decomposition:
- Shared constants header: MODE_*, OP_*, EX_* codes, plus a new EX_MUL = 4'b1010 (unused by existing codes).
- Sub-module mul_sequencer: holds the counter, stall_req and the RUN/MUL_WAIT state. Inputs are start, flush and rst; output is busy.
- The decode table stays in the parent as a combinational always block, then the output register.

Test Plan:
- Reset asserted mid-cycle with the outputs live → all outputs 0 immediately (asynchronous), with no clk edge needed.
- ADD, S=1, valid → next cycle: EX_ADD, WB_en=1, SR_update=1, out_valid=1; has_src1=1 in the same cycle.
- LDR (mode MEM, S=1) → mem_read=1, WB_en=1, SR_update=0; then freeze=1 → following cycle is a bubble, with illegal_instr=0.
- MUL with MUL_CYCLES=3 → EX_MUL for 1 cycle, stall_req high for exactly 2 cycles, then the next instruction decodes. Repeat with MUL_CYCLES=1 → stall_req never asserted.
- MUL, then flush on the 1st MUL_WAIT cycle → stall_req drops the next cycle, state RUN, outputs a bubble.
- mode=2'b11 (undefined), valid → one-cycle illegal_instr pulse, out_valid=0. MOV → has_src1=0; MVN → has_src1=0.
